// File: rtl/lms_fir_adapt.sv
// Sequential LMS adaptive FIR: one shared multiplier, time-multiplexed MAC then optional coefficient update.
// Optional macro LMS_SATURATE_EN saturates y, err and updated coefficients instead of wrapping.
module lms_fir_adapt #(
    parameter int unsigned W        = 32,
    parameter int unsigned TAPS     = 3,
    parameter int unsigned MU_SHIFT = 4,
    parameter int unsigned AW       = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  d,
    input  logic          adapt_en,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_wdata,
    output logic [W-1:0]  coef_rdata,
    output logic [W-1:0]  y,
    output logic [W-1:0]  err,
    output logic          out_valid,
    output logic          busy
);
    localparam int unsigned ACCW = 2 * W + AW;

    typedef enum logic [1:0] {IDLE, MAC, UPDATE} state_t;

    state_t                 state;
    logic [AW-1:0]          idx;
    logic signed [W-1:0]    xd [TAPS];
    logic signed [W-1:0]    h  [TAPS];
    logic signed [W-1:0]    d_lat;
    logic                   adapt_lat;
    logic signed [ACCW-1:0] acc;

    logic signed [W-1:0]    mul_a;
    logic signed [W-1:0]    mul_b;
    logic signed [2*W-1:0]  prod;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW-1:0] upd_sum;
    logic signed [ACCW-1:0] err_full;
    logic signed [W-1:0]    y_new;
    logic signed [W-1:0]    err_new;
    logic signed [W-1:0]    h_upd;
    logic                   last;

`ifdef LMS_SATURATE_EN
    // Clamp a wide signed value into the W-bit two's complement range.
    function automatic logic signed [W-1:0] sat(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] hi;
        logic signed [ACCW-1:0] lo;
        hi = ACCW'({1'b0, {(W-1){1'b1}}});
        lo = -hi - ACCW'(1);
        if (v > hi)      sat = W'(hi);
        else if (v < lo) sat = W'(lo);
        else             sat = W'(v);
    endfunction
`endif

    // Shared multiplier: h*xd while filtering, err*xd while adapting.
    always_comb begin
        last     = (idx == AW'(TAPS - 1));
        mul_a    = (state == UPDATE) ? $signed(err) : h[idx];
        mul_b    = xd[idx];
        prod     = (2*W)'(mul_a) * (2*W)'(mul_b);
        acc_sum  = acc + ACCW'(prod);
        upd_sum  = ACCW'(h[idx]) + ACCW'(prod >>> MU_SHIFT);
`ifdef LMS_SATURATE_EN
        y_new    = sat(acc_sum);
        err_full = ACCW'(d_lat) - ACCW'(y_new);
        err_new  = sat(err_full);
        h_upd    = sat(upd_sum);
`else
        y_new    = W'(acc_sum);
        err_full = ACCW'(d_lat) - ACCW'(y_new);
        err_new  = W'(err_full);
        h_upd    = W'(upd_sum);
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            idx        <= '0;
            d_lat      <= '0;
            adapt_lat  <= 1'b0;
            acc        <= '0;
            y          <= '0;
            err        <= '0;
            coef_rdata <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            for (int unsigned k = 0; k < TAPS; k++) begin
                xd[k] <= '0;
                h[k]  <= '0;
            end
        end else begin
            out_valid  <= 1'b0;
            // Read port sees the array before any write on this edge.
            coef_rdata <= (32'(coef_addr) < TAPS) ? h[coef_addr] : '0;
            case (state)
                IDLE: begin
                    if (coef_we && (32'(coef_addr) < TAPS)) begin
                        h[coef_addr] <= coef_wdata;
                    end
                    if (in_valid) begin
                        xd[0] <= x;
                        for (int unsigned k = 1; k < TAPS; k++) begin
                            xd[k] <= xd[k-1];
                        end
                        d_lat     <= d;
                        adapt_lat <= adapt_en;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= MAC;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (last) begin
                        y         <= y_new;
                        err       <= err_new;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        if (adapt_lat) begin
                            state <= UPDATE;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                UPDATE: begin
                    h[idx] <= h_upd;
                    if (last) begin
                        idx      <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lms_fir_adapt.sv
// Directed bench for lms_fir_adapt (W=32, TAPS=3, MU_SHIFT=4) with hand-computed expectations.
module tb_lms_fir_adapt;
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 2;

    logic                clk = 1'b0;
    logic                clr = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] x = '0;
    logic signed [W-1:0] d = '0;
    logic                adapt_en = 1'b0;
    logic                coef_we = 1'b0;
    logic [AW-1:0]       coef_addr = '0;
    logic signed [W-1:0] coef_wdata = '0;
    logic signed [W-1:0] coef_rdata;
    logic signed [W-1:0] y;
    logic signed [W-1:0] err;
    logic                out_valid;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    int p0;

    lms_fir_adapt #(.W(W), .TAPS(3), .MU_SHIFT(4)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .d(d), .adapt_en(adapt_en), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_rdata(coef_rdata),
        .y(y), .err(err), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic signed [W-1:0] v);
        coef_we = 1'b1; coef_addr = a; coef_wdata = v;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic signed [W-1:0] exp);
        coef_addr = a;
        tick();
        chk(tag, coef_rdata, exp);
    endtask

    task automatic accept(input logic signed [W-1:0] xv, input logic signed [W-1:0] dv, input logic ad);
        x = xv; d = dv; adapt_en = ad; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        tick();
        tick();
        clr = 1'b1;
    endtask

    task automatic load121();
        wr(0, 1); wr(1, 2); wr(2, 1);
    endtask

    // Two MAC edges silent, pulse with y/err on the third.
    task automatic expect_out(input string tag, input logic signed [W-1:0] ey, input logic signed [W-1:0] ee);
        tick();
        tick();
        chk({tag, "_early"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_err"}, err, ee);
    endtask

    initial begin
        // Reset
        do_reset();
        chk("rst_y", y, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        for (int a = 0; a < 4; a++) rd($sformatf("rst_coef%0d", a), AW'(a), 0);
        wr(3, 55);
        rd("oob_read", 3, 0);

        // Fixed filter h={1,2,1}
        load121();
        accept(5, 1100, 0);
        expect_out("fix1", 5, 1095);
        chk("fix1_ready", in_ready, 1);
        accept(5, 1100, 0);
        expect_out("fix2", 15, 1085);
        accept(5, 1100, 0);
        expect_out("fix3", 20, 1080);
        rd("fix_h0", 0, 1);
        rd("fix_h1", 1, 2);
        rd("fix_h2", 2, 1);

        // Single adaptation from empty delay line
        do_reset();
        load121();
        accept(5, 1100, 1);
        coef_addr = 0;
        expect_out("ad", 5, 1095);
        tick();
        chk("ad_rdata_old", coef_rdata, 1);
        chk("ad_ready_t4", in_ready, 0);
        tick();
        chk("ad_rdata_new", coef_rdata, 343);
        chk("ad_busy_t5", busy, 1);
        tick();
        chk("ad_ready_t6", in_ready, 1);
        chk("ad_busy_t6", busy, 0);
        rd("ad_h1", 1, 2);
        rd("ad_h2", 2, 1);

        // Negative error
        do_reset();
        load121();
        accept(-8, 0, 1);
        expect_out("neg", -8, 8);
        tick(); tick(); tick();
        rd("neg_h0", 0, -3);
        rd("neg_h1", 1, 2);

        // Busy collisions: h={-3,2,1}, xd={-8,0,0}
        p0 = pulses;
        x = 1; d = 0; adapt_en = 0; in_valid = 1'b1;
        tick();
        x = 2;
        coef_we = 1'b1; coef_addr = 1; coef_wdata = 99;
        tick();
        coef_we = 1'b0;
        tick();
        chk("col_rdata_h1", coef_rdata, 2);
        tick();
        chk("col1_valid", out_valid, 1);
        chk("col1_y", y, -19);
        chk("col1_err", err, 19);
        tick();
        chk("col_accept_busy", busy, 1);
        in_valid = 1'b0;
        expect_out("col2", -12, 12);
        tick(); tick();
        chk("col_pulses", pulses - p0, 2);
        rd("col_h1", 1, 2);

        // Overflow, with write and acceptance on the same edge
        do_reset();
        coef_we = 1'b1; coef_addr = 0; coef_wdata = 32'sh7FFF_FFFF;
        x = 2; d = 0; adapt_en = 0; in_valid = 1'b1;
        tick();
        coef_we = 1'b0; in_valid = 1'b0;
`ifdef LMS_SATURATE_EN
        expect_out("ovf", 32'sh7FFF_FFFF, -32'sh7FFF_FFFF);
`else
        expect_out("ovf", -2, 2);
`endif

        // Abort mid-UPDATE
        accept(1, 0, 1);
        tick(); tick(); tick();
        tick();
        p0 = pulses;
        #2;
        clr = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_y", y, 0);
        tick();
        clr = 1'b1;
        tick(); tick(); tick();
        chk("abort_pulses", pulses - p0, 0);
        rd("abort_h0", 0, 0);
        rd("abort_h1", 1, 0);
        rd("abort_h2", 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
